// File: rtl/seg7_pkg.sv
// Shared constants and helpers for the multiplexed seven-segment display path.
// Segment codes are active-low, bit order {g,f,e,d,c,b,a}.
package seg7_pkg;

  localparam int NDIG = 4;

  typedef logic [3:0] nibble_t;

  localparam logic [6:0] SEG_0    = 7'h40;
  localparam logic [6:0] SEG_1    = 7'h79;
  localparam logic [6:0] SEG_2    = 7'h24;
  localparam logic [6:0] SEG_3    = 7'h30;
  localparam logic [6:0] SEG_4    = 7'h19;
  localparam logic [6:0] SEG_5    = 7'h12;
  localparam logic [6:0] SEG_6    = 7'h02;
  localparam logic [6:0] SEG_7    = 7'h78;
  localparam logic [6:0] SEG_8    = 7'h00;
  localparam logic [6:0] SEG_9    = 7'h10;
  localparam logic [6:0] SEG_DASH = 7'h3F;
  localparam logic [6:0] SEG_OFF  = 7'h7F;

  // True when exactly one bit is set.
  function automatic logic is_onehot4(input logic [3:0] v);
    return (v != 4'b0000) && ((v & (v - 4'd1)) == 4'b0000);
  endfunction

  function automatic logic [1:0] onehot_to_idx(input logic [3:0] v);
    logic [1:0] idx;
    idx = 2'd0;
    for (int i = 0; i < NDIG; i++) begin
      if (v[i]) idx = 2'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/bcd_to_seg7.sv
// Combinational BCD nibble to active-low segment decoder.
// Non-decimal nibbles show a dash; blank overrides everything.
module bcd_to_seg7
  import seg7_pkg::*;
(
  input  logic [3:0] nibble,
  input  logic       blank,
  output logic [6:0] seg_n
);

  always_comb begin
    seg_n = SEG_OFF;
    if (!blank) begin
      case (nibble)
        4'd0:    seg_n = SEG_0;
        4'd1:    seg_n = SEG_1;
        4'd2:    seg_n = SEG_2;
        4'd3:    seg_n = SEG_3;
        4'd4:    seg_n = SEG_4;
        4'd5:    seg_n = SEG_5;
        4'd6:    seg_n = SEG_6;
        4'd7:    seg_n = SEG_7;
        4'd8:    seg_n = SEG_8;
        4'd9:    seg_n = SEG_9;
        default: seg_n = SEG_DASH;
      endcase
    end
  end

endmodule

// File: rtl/seg7_scan_driver.sv
// Four-digit common-anode scan driver fed by a one-hot ring counter.
// New BCD values wait in a shadow register and go live only on entry to digit 0.
module seg7_scan_driver
  import seg7_pkg::*;
#(
  parameter bit LZB_EN = 1'b1,
  parameter int ERR_W  = 8
) (
  input  logic             Clock,
  input  logic             Reset,
  input  logic [3:0]       Count_in,
  input  logic             load,
  input  logic [15:0]      bcd_in,
  output logic             load_ack,
  output logic [3:0]       anode_n,
  output logic [6:0]       seg_n,
  output logic             onehot_err,
  output logic [ERR_W-1:0] err_count
);

  logic [15:0]      shadow_reg;
  logic [15:0]      active_reg;
  logic             pending_reg;
  logic [3:0]       prev_sel_reg;
  logic             load_ack_reg;
  logic [3:0]       anode_n_reg;
  logic [6:0]       seg_n_reg;
  logic             onehot_err_reg;
  logic [ERR_W-1:0] err_count_reg;

  logic             sel_legal;
  logic [1:0]       sel_idx;
  logic             commit;
  logic [15:0]      src;
  logic [NDIG-1:0]  nib_zero;
  logic [NDIG-1:0]  blank;
  logic [6:0]       digit_seg [NDIG];
  logic [6:0]       seg_next;

  assign sel_legal = is_onehot4(Count_in);
  assign sel_idx   = onehot_to_idx(Count_in);

  // Commit only on the edge into digit 0, so a held 0001 cannot re-commit.
  assign commit = sel_legal && (Count_in == 4'b0001) &&
                  (prev_sel_reg != 4'b0001) && pending_reg;

  // The committing frame already shows the new value on digit 0.
  assign src = commit ? shadow_reg : active_reg;

  for (genvar gi = 0; gi < NDIG; gi++) begin : g_digit
    assign nib_zero[gi] = (src[gi*4 +: 4] == 4'd0);

    if (gi == 0) begin : g_lsd
      assign blank[gi] = 1'b0;
    end else begin : g_upper
      assign blank[gi] = LZB_EN && (&nib_zero[NDIG-1:gi]);
    end

    bcd_to_seg7 u_dec (
      .nibble (src[gi*4 +: 4]),
      .blank  (blank[gi]),
      .seg_n  (digit_seg[gi])
    );
  end

  assign seg_next = digit_seg[sel_idx];

  always_ff @(posedge Clock) begin
    if (Reset) begin
      shadow_reg     <= 16'h0000;
      active_reg     <= 16'h0000;
      pending_reg    <= 1'b0;
      prev_sel_reg   <= 4'b0000;
      load_ack_reg   <= 1'b0;
      anode_n_reg    <= 4'b1111;
      seg_n_reg      <= SEG_OFF;
      onehot_err_reg <= 1'b0;
      err_count_reg  <= '0;
    end else begin
      prev_sel_reg <= Count_in;
      load_ack_reg <= load;

      if (commit) begin
        active_reg  <= shadow_reg;
        pending_reg <= 1'b0;
      end
      // A load on the commit edge refills the shadow and keeps it pending.
      if (load) begin
        shadow_reg  <= bcd_in;
        pending_reg <= 1'b1;
      end

      if (sel_legal) begin
        anode_n_reg    <= ~Count_in;
        seg_n_reg      <= seg_next;
        onehot_err_reg <= 1'b0;
      end else begin
        anode_n_reg    <= 4'b1111;
        seg_n_reg      <= SEG_OFF;
        onehot_err_reg <= 1'b1;
        if (err_count_reg != {ERR_W{1'b1}}) begin
          err_count_reg <= err_count_reg + {{(ERR_W-1){1'b0}}, 1'b1};
        end
      end
    end
  end

  assign load_ack   = load_ack_reg;
  assign anode_n    = anode_n_reg;
  assign seg_n      = seg_n_reg;
  assign onehot_err = onehot_err_reg;
  assign err_count  = err_count_reg;

endmodule

// File: tb/tb_seg7_scan_driver.sv
// Scoreboard bench for seg7_scan_driver: stimulus pushes expected outputs,
// a monitor pops and compares one cycle after each sampled input.
module tb_seg7_scan_driver;

  logic        clk;
  logic        rst;
  logic [3:0]  sel;
  logic        ld;
  logic [15:0] bcd;

  logic        ack_a, oe_a, ack_b, oe_b;
  logic [3:0]  an_a, an_b;
  logic [6:0]  seg_a, seg_b;
  logic [7:0]  cnt_a, cnt_b;

  seg7_scan_driver #(.LZB_EN(1'b1), .ERR_W(8)) dut (
    .Clock(clk), .Reset(rst), .Count_in(sel), .load(ld), .bcd_in(bcd),
    .load_ack(ack_a), .anode_n(an_a), .seg_n(seg_a),
    .onehot_err(oe_a), .err_count(cnt_a)
  );

  seg7_scan_driver #(.LZB_EN(1'b0), .ERR_W(8)) dut_nolzb (
    .Clock(clk), .Reset(rst), .Count_in(sel), .load(ld), .bcd_in(bcd),
    .load_ack(ack_b), .anode_n(an_b), .seg_n(seg_b),
    .onehot_err(oe_b), .err_count(cnt_b)
  );

  typedef struct {
    logic [3:0] an;
    logic [6:0] seg;
    logic       oe;
    logic       ack;
    logic [7:0] cnt;
    int         seg_nz;
    string      nm;
  } exp_t;

  exp_t exp_q[$];
  int   tests  = 0;
  int   errors = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // seg_nz >= 0 additionally checks the LZB-disabled instance.
  task automatic step(input logic rst_i, input logic [3:0] sel_i, input logic ld_i,
                      input logic [15:0] bcd_i, input logic [3:0] an_e,
                      input logic [6:0] seg_e, input logic oe_e, input int cnt_e,
                      input string nm, input int seg_nz = -1);
    exp_t e;
    @(negedge clk);
    rst = rst_i; sel = sel_i; ld = ld_i; bcd = bcd_i;
    e.an = an_e; e.seg = seg_e; e.oe = oe_e; e.ack = ld_i && !rst_i;
    e.cnt = 8'(cnt_e); e.seg_nz = seg_nz; e.nm = nm;
    exp_q.push_back(e);
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        tests += 5;
        if (an_a !== e.an) begin
          errors++; $display("FAIL %s anode_n: got %b expected %b", e.nm, an_a, e.an);
        end
        if (seg_a !== e.seg) begin
          errors++; $display("FAIL %s seg_n: got %h expected %h", e.nm, seg_a, e.seg);
        end
        if (oe_a !== e.oe) begin
          errors++; $display("FAIL %s onehot_err: got %b expected %b", e.nm, oe_a, e.oe);
        end
        if (ack_a !== e.ack) begin
          errors++; $display("FAIL %s load_ack: got %b expected %b", e.nm, ack_a, e.ack);
        end
        if (cnt_a !== e.cnt) begin
          errors++; $display("FAIL %s err_count: got %0d expected %0d", e.nm, cnt_a, e.cnt);
        end
        if (e.seg_nz >= 0) begin
          tests++;
          if (seg_b !== 7'(e.seg_nz)) begin
            errors++;
            $display("FAIL %s seg_n(nolzb): got %h expected %h", e.nm, seg_b, 7'(e.seg_nz));
          end
        end
        $display("[TB] %s sel_in=%b an=%b seg=%h oe=%b ack=%b cnt=%0d",
                 e.nm, sel, an_a, seg_a, oe_a, ack_a, cnt_a);
      end
    end
  end

  initial begin : stimulus
    rst = 1'b1; sel = 4'b0000; ld = 1'b0; bcd = 16'h0000;

    // Reset and first commit of 1234
    step(1, 4'b0000, 0, 16'h0000, 4'hF, 7'h7F, 0, 0, "reset");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h40, 0, 0, "f0_d0");
    step(0, 4'b0010, 1, 16'h1234, 4'hD, 7'h7F, 0, 0, "f0_d1_ld");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h7F, 0, 0, "f0_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "f0_d3");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h19, 0, 0, "f1_d0_commit");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h30, 0, 0, "f1_d1");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h24, 0, 0, "f1_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h79, 0, 0, "f1_d3");

    // Leading-zero blanking with 0050, both LZB settings
    step(1, 4'b0000, 0, 16'h0000, 4'hF, 7'h7F, 0, 0, "reset2");
    step(0, 4'b0001, 1, 16'h0050, 4'hE, 7'h40, 0, 0, "lz_ld", 'h40);
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h7F, 0, 0, "lz_pre_d1", 'h40);
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h7F, 0, 0, "lz_pre_d2", 'h40);
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "lz_pre_d3", 'h40);
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h40, 0, 0, "lz_d0", 'h40);
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h12, 0, 0, "lz_d1", 'h12);
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h7F, 0, 0, "lz_d2", 'h40);
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "lz_d3", 'h40);

    // Mid-frame reload does not tear the current frame
    step(0, 4'b0001, 1, 16'h1234, 4'hE, 7'h40, 0, 0, "mf_ld1");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h12, 0, 0, "mf_old_d1");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h7F, 0, 0, "mf_old_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "mf_old_d3");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h19, 0, 0, "mf_a_d0");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h30, 0, 0, "mf_a_d1");
    step(0, 4'b0100, 1, 16'h00AF, 4'hB, 7'h24, 0, 0, "mf_a_d2_ld2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h79, 0, 0, "mf_a_d3");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h3F, 0, 0, "mf_b_d0");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h3F, 0, 0, "mf_b_d1");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h7F, 0, 0, "mf_b_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "mf_b_d3");

    // Load on the same edge as a commit
    step(0, 4'b0001, 1, 16'h0321, 4'hE, 7'h3F, 0, 0, "sc_ld1");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h3F, 0, 0, "sc_p_d1");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h7F, 0, 0, "sc_p_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "sc_p_d3");
    step(0, 4'b0001, 1, 16'h0789, 4'hE, 7'h79, 0, 0, "sc_commit_ld2");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h24, 0, 0, "sc_a_d1");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h30, 0, 0, "sc_a_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "sc_a_d3");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h10, 0, 0, "sc_b_d0");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h00, 0, 0, "sc_b_d1");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h78, 0, 0, "sc_b_d2");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "sc_b_d3");

    // Illegal selects, then commit after 0110
    step(0, 4'b0001, 1, 16'h0456, 4'hE, 7'h10, 0, 0, "oh_ld");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h00, 0, 0, "oh_d1");
    step(0, 4'b0000, 0, 16'h0000, 4'hF, 7'h7F, 1, 1, "oh_zero");
    step(0, 4'b0110, 0, 16'h0000, 4'hF, 7'h7F, 1, 2, "oh_two");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h02, 0, 2, "oh_commit");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h12, 0, 2, "oh_d1b");
    step(0, 4'b0100, 0, 16'h0000, 4'hB, 7'h19, 0, 2, "oh_d2b");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 2, "oh_d3b");

    // Saturation of the error counter
    for (int k = 1; k <= 300; k++) begin
      step(0, (k % 2 == 1) ? 4'b0000 : 4'b1100, 0, 16'h0000, 4'hF, 7'h7F, 1,
           (2 + k > 255) ? 255 : 2 + k, "sat");
    end

    // Reset mid-scan discards the pending value
    step(0, 4'b0001, 1, 16'h9999, 4'hE, 7'h02, 0, 255, "mr_ld");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h12, 0, 255, "mr_d1");
    step(1, 4'b0100, 0, 16'h0000, 4'hF, 7'h7F, 0, 0, "mr_reset");
    step(0, 4'b1000, 0, 16'h0000, 4'h7, 7'h7F, 0, 0, "mr_d3");
    step(0, 4'b0001, 0, 16'h0000, 4'hE, 7'h40, 0, 0, "mr_no_commit");
    step(0, 4'b0010, 0, 16'h0000, 4'hD, 7'h7F, 0, 0, "mr_d1b");

    @(negedge clk);
    rst = 1'b0; sel = 4'b0001; ld = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    tests++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending expectations expected 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end

endmodule
